tdc_pulse_gen: RTL and testbench

- Digital-to-time stimulus generator: the transmit end of the TDC measurement path.
- Accepts 20-bit time codes in the same coarse/fine format the TDC produces, queues them, and on each start trigger emits a pulse on `signal` delayed by the coded coarse cycle count.
- Presents the fine part on `phase_sel` for an external PLL-phase mux.
- Used for on-board TDC self-calibration and loopback.

---
 rtl/tdc_pulse_gen_if.sv | 12 +
 rtl/tdc_pulse_gen.sv | 167 ++++++++++++++++
 tb/tb_tdc_pulse_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tdc_pulse_gen_if.sv
// Push-side handshake of the TDC stimulus generator: a time code plus a
// valid/ready pair. The producer drives the master modport.
interface tdc_pulse_gen_if #(
  parameter int TIME_W = 20
);
  logic [TIME_W-1:0] in_time;
  logic              in_dval;
  logic              in_ready;

  modport master (output in_time, output in_dval, input in_ready);
  modport slave  (input in_time, input in_dval, output in_ready);
endinterface

// File: rtl/tdc_pulse_gen.sv
// Digital-to-time stimulus generator: queues coarse/fine time codes and, per start
// trigger, emits a PULSE_LEN pulse after the coarse delay. Optional macro PG_REPEAT_EN.
module tdc_pulse_gen #(
  parameter int TIME_W     = 20,
  parameter int FRAC_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_LEN  = 8
) (
  input  logic                  pll_clk,
  input  logic                  rst,
  tdc_pulse_gen_if.slave        pin,
  input  logic                  start,
  output logic                  signal,
  output logic [FRAC_W-1:0]     phase_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = TIME_W - FRAC_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, PULSE, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [CW-1:0]     coarse_q, coarse_nxt;
  logic [FRAC_W-1:0] phase_nxt;
  logic              signal_nxt, done_nxt, err_nxt;

  // Stage p0..p2: start synchroniser plus delayed copy for edge detection
  logic start_s_p0, start_s_p1, start_d_p2;
  logic start_edge;

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      start_s_p0 <= 1'b0;
      start_s_p1 <= 1'b0;
      start_d_p2 <= 1'b0;
    end else begin
      start_s_p0 <= start;
      start_s_p1 <= start_s_p0;
      start_d_p2 <= start_s_p1;
    end
  end

  assign start_edge = start_s_p1 & ~start_d_p2;

  // Code FIFO: pointers carry one wrap bit so full and empty are distinguishable
  logic [TIME_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, pop;
  logic [TIME_W-1:0] head;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pin.in_ready = ~fifo_full;
  assign push         = pin.in_dval & ~fifo_full;
  assign head         = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pll_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pin.in_time;
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  logic              launch_ok;
  logic [TIME_W-1:0] launch_code;
`ifdef PG_REPEAT_EN
  logic [TIME_W-1:0] last_code;

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst)     last_code <= '0;
    else if (pop) last_code <= head;
  end

  assign launch_ok   = 1'b1;
  assign launch_code = fifo_empty ? last_code : head;
`else
  assign launch_ok   = ~fifo_empty;
  assign launch_code = head;
`endif

  // Control FSM: cnt counts the coarse delay in COUNT, then pulse width in PULSE
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    coarse_nxt = coarse_q;
    phase_nxt  = phase_sel;
    signal_nxt = signal;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          if (launch_ok) begin
            state_nxt  = COUNT;
            pop        = ~fifo_empty;
            coarse_nxt = launch_code[TIME_W-1:FRAC_W];
            phase_nxt  = launch_code[FRAC_W-1:0];
            cnt_nxt    = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      COUNT: begin
        err_nxt = start_edge;
        if (cnt == coarse_q) begin
          state_nxt  = PULSE;
          signal_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PULSE: begin
        err_nxt = start_edge;
        if (cnt == CW'(PULSE_LEN - 1)) begin
          state_nxt  = DONE;
          signal_nxt = 1'b0;
          done_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        err_nxt   = start_edge;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      signal    <= 1'b0;
      phase_sel <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      signal    <= signal_nxt;
      phase_sel <= phase_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_ff @(posedge pll_clk) begin
    coarse_q <= coarse_nxt;
  end

  assign busy = (state == COUNT) || (state == PULSE);

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Directed bench for tdc_pulse_gen: per-edge checks of pulse timing, FIFO order,
// dropped-start strobes and async reset; PG_REPEAT_EN changes empty-start outcomes.
module tb_tdc_pulse_gen;
  localparam int TIME_W = 20;
  localparam int FRAC_W = 4;
`ifdef PG_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic              pll_clk;
  logic              rst;
  logic              start;
  logic              signal;
  logic [FRAC_W-1:0] phase_sel;
  logic              busy, done, err;

  int total = 0;
  int bad   = 0;

  tdc_pulse_gen_if #(.TIME_W(TIME_W)) pif ();

  tdc_pulse_gen #(
    .TIME_W(TIME_W), .FRAC_W(FRAC_W), .FIFO_DEPTH(4), .PULSE_LEN(8)
  ) dut (
    .pll_clk  (pll_clk),
    .rst      (rst),
    .pin      (pif),
    .start    (start),
    .signal   (signal),
    .phase_sel(phase_sel),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [TIME_W-1:0] code);
    @(negedge pll_clk);
    pif.in_time = code;
    pif.in_dval = 1'b1;
    @(negedge pll_clk);
    pif.in_dval = 1'b0;
  endtask

  // Edge k=1 is the first rising edge after start goes high; E0 is edge 3 (j=0).
  task automatic run_start(input int coarse, input logic [3:0] ph,
                           input bit launch, input bit retrig);
    int last;
    int j;
    last = launch ? coarse + 12 : 4;
    for (int k = 1; k <= last + 3; k++) begin
      @(negedge pll_clk);
      if (k == 1) start = 1'b1;
      if (k == 4) start = 1'b0;
      if (retrig && k == 6) start = 1'b1;
      if (retrig && k == 9) start = 1'b0;
      @(posedge pll_clk);
      #1;
      j = k - 3;
      chk($sformatf("signal c%0d j%0d", coarse, j), 32'(signal),
          32'(launch && j >= coarse + 1 && j <= coarse + 8));
      chk($sformatf("busy c%0d j%0d", coarse, j), 32'(busy),
          32'(launch && j >= 0 && j <= coarse + 8));
      chk($sformatf("done c%0d j%0d", coarse, j), 32'(done),
          32'(launch && j == coarse + 9));
      chk($sformatf("err c%0d j%0d", coarse, j), 32'(err),
          32'((!launch && j == 0) || (retrig && j == 5)));
      if (j >= 0) chk($sformatf("phase c%0d j%0d", coarse, j), 32'(phase_sel), 32'(ph));
    end
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    pif.in_time = '0;
    pif.in_dval = 1'b0;
    repeat (3) @(posedge pll_clk);
    #1;
    chk("rst signal", 32'(signal), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst phase", 32'(phase_sel), 32'd0);
    chk("rst ready", 32'(pif.in_ready), 32'd1);
    @(negedge pll_clk);
    rst = 1'b1;

    // Basic delays: coarse 5 fine 0, then coarse 3 fine A
    push(20'h00050);
    run_start(5, 4'h0, 1'b1, 1'b0);
    push(20'h0003A);
    run_start(3, 4'hA, 1'b1, 1'b0);

    // Fill FIFO, overflow push ignored, drain in order
    push(20'h00010);
    push(20'h00021);
    push(20'h00002);
    push(20'h00020);
    chk("full ready", 32'(pif.in_ready), 32'd0);
    push(20'h000F5);
    chk("full ready after extra push", 32'(pif.in_ready), 32'd0);
    run_start(1, 4'h0, 1'b1, 1'b0);
    chk("ready after pop", 32'(pif.in_ready), 32'd1);
    run_start(2, 4'h1, 1'b1, 1'b0);
    run_start(0, 4'h2, 1'b1, 1'b0);
    run_start(2, 4'h0, 1'b1, 1'b0);

    // Empty FIFO: err (or relaunch of last code 0x00020 in repeat mode)
    run_start(2, 4'h0, REP, 1'b0);

    // Retrigger during COUNT must not pop the queued second code
    push(20'h00080);
    push(20'h00017);
    run_start(8, 4'h0, 1'b1, 1'b1);
    run_start(1, 4'h7, 1'b1, 1'b0);

    // Async reset in the middle of a pulse
    push(20'h00030);
    push(20'h00045);
    for (int k = 1; k <= 8; k++) begin
      @(negedge pll_clk);
      if (k == 1) start = 1'b1;
      if (k == 4) start = 1'b0;
      @(posedge pll_clk);
    end
    #1;
    chk("pre-reset signal", 32'(signal), 32'd1);
    chk("pre-reset phase", 32'(phase_sel), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid-rst signal", 32'(signal), 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst phase", 32'(phase_sel), 32'd0);
    chk("mid-rst ready", 32'(pif.in_ready), 32'd1);
    @(negedge pll_clk);
    rst = 1'b1;
    repeat (2) @(negedge pll_clk);
    run_start(0, 4'h0, REP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
